// File: rtl/subtrator_serial.sv
// ---------------------------------------------------------------------------
// subtrator_serial
//
// Bit-serial unsigned subtractor. It computes a - b modulo 2^WIDTH one bit
// per clock, LSB first, and also reports the final borrow.
//
// Operation
//   IDLE  : on start, latch a/b, clear the borrow flop and the bit counter.
//   SHIFT : WIDTH cycles, one difference bit per cycle.
//   DONE  : one cycle with done high, then back to IDLE unconditionally.
// A start accepted at edge k gives done high during the cycle after edge
// k+WIDTH. start is ignored outside IDLE.
//
// Handshake: start is a request that is only honoured while the block is in
// IDLE (busy=0, done=0). There is no back-pressure; a start seen in SHIFT or
// DONE is dropped. done is a one-cycle pulse and diff/borrow_out (and
// overflow) stay stable from that pulse until the next completion.
//
// Optional feature
//   SUBTRATOR_SERIAL_OVERFLOW_EN : adds output 'overflow', the two's-complement
//   signed overflow of the latched operands, registered together with diff.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a subtraction (honoured only in IDLE)
//   a          in   minuend   [WIDTH-1:0], sampled on accepted start
//   b          in   subtrahend[WIDTH-1:0], sampled on accepted start
//   busy       out  high while in SHIFT
//   done       out  one-cycle completion pulse
//   diff       out  a - b mod 2^WIDTH
//   borrow_out out  high when a < b (unsigned)
//   overflow   out  signed overflow (only with SUBTRATOR_SERIAL_OVERFLOW_EN)
// ---------------------------------------------------------------------------
module subtrator_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One full-subtractor slice on the current LSBs.
    logic diff_bit;
    logic br_next;
    logic [WIDTH-1:0] res_shifted;

`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
    // Operand sign bits are kept aside because the operand registers are
    // shifted away by the time the result is known.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        diff_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_shifted = {diff_bit, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shifted;
                br_d   = br_next;
                if (cnt_q == LAST_CNT) begin
                    // Last bit: publish the complete result in one step so
                    // the outputs never show a partial value.
                    diff_d   = res_shifted;
                    borrow_d = br_next;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
                    ovf_d    = (a_msb_q != b_msb_q) & (diff_bit != a_msb_q);
`endif
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
    assign overflow   = ovf_q;
`endif

endmodule
